// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR tap sequencer slice.
package fir_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Tap select width; caps a slice at 15 taps.
   localparam int SEL_W            = 4;
   localparam int DEF_DATA_WIDTH   = 15;
   localparam int DEF_COEFF_WIDTH  = 16;
   localparam int DEF_TAPS         = 5;
endpackage

// File: rtl/fir_coeff_bank.sv
// Per-slice coefficient register file with host write port and async read.
module fir_coeff_bank
   import fir_pkg::*;
#(
   parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
   parameter int TAPS        = DEF_TAPS
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we_i,     // already gated by the FSM state
   input  logic [SEL_W-1:0]       waddr_i,
   input  logic [COEFF_WIDTH-1:0] wdata_i,
   input  logic [SEL_W-1:0]       raddr_i,
   output logic [COEFF_WIDTH-1:0] rdata_o
);
   localparam logic [SEL_W-1:0] NUM_TAPS = SEL_W'(TAPS);

   logic [TAPS-1:0][COEFF_WIDTH-1:0] mem_q;
   logic                             wr_ok;

   assign wr_ok = we_i && (waddr_i < NUM_TAPS);

   // Register file; out-of-range addresses never match an entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < TAPS; i++) begin
            if (waddr_i == SEL_W'(i)) mem_q[i] <= wdata_i;
         end
      end
   end

   // Asynchronous read mux; unmatched index reads 0.
   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (raddr_i == SEL_W'(i)) rdata_o = mem_q[i];
      end
   end
endmodule

// File: rtl/fir_tap_seq.sv
// Tap sequencer and sample delay line for one MAC slice of the FIR filter.
module fir_tap_seq
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
   parameter int TAPS        = DEF_TAPS
) (
   input  logic                          iClk_12M,
   input  logic                          iRst,
   input  logic                          iEnSample,
   input  logic signed [DATA_WIDTH-1:0]  iFirIn,
   input  logic                          iCoeffWe,
   input  logic [SEL_W-1:0]              iCoeffAddr,
   input  logic signed [COEFF_WIDTH-1:0] iCoeffData,
   output logic [TAPS*DATA_WIDTH-1:0]    oDelay,
   output logic signed [COEFF_WIDTH-1:0] oCoeff,
   output logic [SEL_W-1:0]              oEnMul,
   output logic                          oEnAdd,
   output logic                          oEnAcc,
   output logic                          oDone,
   output logic                          oBusy,
   output logic                          oOverrun
);
   localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS);

   state_t                          state_q, state_d;
   logic [SEL_W-1:0]                tap_q, tap_d;
   logic [TAPS-1:0][DATA_WIDTH-1:0] delay_q;
   logic                            overrun_q;
   logic                            accept;
   logic                            busy;
   logic [SEL_W-1:0]                rd_idx;
   logic [COEFF_WIDTH-1:0]          coeff_rd;

   // Next-state, tap counter and decoded controls.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      accept  = 1'b0;
      busy    = (state_q == RUN);
      oEnMul  = '0;
      oEnAdd  = 1'b0;
      oEnAcc  = 1'b0;
      oDone   = 1'b0;
      rd_idx  = '0;
      case (state_q)
         IDLE, DONE: begin
            oDone   = (state_q == DONE);
            state_d = IDLE;
            tap_d   = '0;
            if (iEnSample) begin
               accept  = 1'b1;
               state_d = RUN;
               tap_d   = SEL_W'(1);
            end
         end
         RUN: begin
            oEnMul = tap_q;
            oEnAdd = 1'b1;
            oEnAcc = 1'b1;
            rd_idx = tap_q - 1'b1;
            if (tap_q == LAST_TAP) begin
               state_d = DONE;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tap_d   = '0;
         end
      endcase
   end

   // FSM state, tap counter and sticky overrun flag.
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         state_q   <= IDLE;
         tap_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         if (iEnSample && busy) overrun_q <= 1'b1;
      end
   end

   // Delay line shifts only on an accepted strobe; index 0 is tap 1.
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         delay_q <= '0;
      end else if (accept) begin
         delay_q[0] <= iFirIn;
         for (int i = 1; i < TAPS; i++) delay_q[i] <= delay_q[i-1];
      end
   end

   fir_coeff_bank #(
      .COEFF_WIDTH (COEFF_WIDTH),
      .TAPS        (TAPS)
   ) u_bank (
      .clk_i   (iClk_12M),
      .rst_i   (iRst),
      .we_i    (iCoeffWe && !busy),
      .waddr_i (iCoeffAddr),
      .wdata_i (iCoeffData),
      .raddr_i (rd_idx),
      .rdata_o (coeff_rd)
   );

   assign oCoeff   = busy ? coeff_rd : '0;
   assign oDelay   = delay_q;
   assign oBusy    = busy;
   assign oOverrun = overrun_q;
endmodule
